// File: rtl/sd_cmd_arb_pkg.sv
// Shared types and constants for the SD command-path arbiter.
// Build option: SD_CMD_ARB_RR_EN selects round-robin instead of fixed B priority.
package sd_cmd_arb_pkg;

    // Widths follow the values in sd_defines.vh of the SD controller.
    localparam int CMD_REG_SIZE  = 14;
    localparam int CMD_TIMEOUT_W = 24;
    localparam int INT_CMD_SIZE  = 5;

    localparam int INT_CMD_CC    = 0;
    localparam int INT_CMD_EI    = 1;
    localparam int INT_CMD_CTE   = 2;
    localparam int INT_CMD_CCRCE = 3;
    localparam int INT_CMD_CIE   = 4;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // Either command-complete or command-timeout ends the owner's transaction.
    localparam logic [INT_CMD_SIZE-1:0] DONE_MASK =
        INT_CMD_SIZE'((1 << INT_CMD_CC) | (1 << INT_CMD_CTE));

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RELEASE
    } arb_state_e;

    function automatic logic is_done(input logic [INT_CMD_SIZE-1:0] st);
        return |(st & DONE_MASK);
    endfunction

endpackage

// File: rtl/sd_cmd_arb_pick.sv
// Combinational winner selection between the host (A) and auto-command (B) ports.
// Build option: SD_CMD_ARB_RR_EN adds the last-granted input for round-robin.
module sd_cmd_arb_pick
    import sd_cmd_arb_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
`ifdef SD_CMD_ARB_RR_EN
    input  logic last,
`endif
    output logic valid,
    output logic winner
);

    always_comb begin
        valid  = req_a | req_b;
        winner = PORT_A;
        if (req_a && req_b) begin
`ifdef SD_CMD_ARB_RR_EN
            winner = (last == PORT_B) ? PORT_A : PORT_B;
`else
            winner = PORT_B;
`endif
        end else if (req_b) begin
            winner = PORT_B;
        end
    end

endmodule

// File: rtl/sd_cmd_arbiter.sv
// Two-port arbiter in front of the SD command master: grant, start, wait, release.
// Build option: SD_CMD_ARB_RR_EN enables round-robin on simultaneous requests.
module sd_cmd_arbiter
    import sd_cmd_arb_pkg::*;
(
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     clock_posedge,
    input  logic                     req_a,
    input  logic                     req_b,
    input  logic [CMD_REG_SIZE-1:0]  cmd_a,
    input  logic [CMD_REG_SIZE-1:0]  cmd_b,
    input  logic [31:0]              arg_a,
    input  logic [31:0]              arg_b,
    input  logic [CMD_TIMEOUT_W-1:0] tmo_a,
    input  logic [CMD_TIMEOUT_W-1:0] tmo_b,
    output logic                     ack_a,
    output logic                     ack_b,
    output logic                     done_a,
    output logic                     done_b,
    output logic [INT_CMD_SIZE-1:0]  status_a,
    output logic [INT_CMD_SIZE-1:0]  status_b,
    output logic                     owner_o,
    output logic                     mst_start_o,
    output logic [CMD_REG_SIZE-1:0]  mst_command_o,
    output logic [31:0]              mst_argument_o,
    output logic [CMD_TIMEOUT_W-1:0] mst_timeout_o,
    output logic                     mst_int_status_rst_o,
    input  logic [INT_CMD_SIZE-1:0]  mst_int_status_i
);

    arb_state_e state, state_d;
    logic       pick_valid, pick_winner;
    logic       grant, start_d, irst_d, finish;

`ifdef SD_CMD_ARB_RR_EN
    logic last_q;

    sd_cmd_arb_pick u_pick (
        .req_a  (req_a),
        .req_b  (req_b),
        .last   (last_q),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    always_ff @(posedge clock) begin
        if (!rst)
            last_q <= PORT_B;
        else if (clock_posedge && grant)
            last_q <= pick_winner;
    end
`else
    sd_cmd_arb_pick u_pick (
        .req_a  (req_a),
        .req_b  (req_b),
        .valid  (pick_valid),
        .winner (pick_winner)
    );
`endif

    always_ff @(posedge clock) begin
        if (!rst)
            state <= ST_IDLE;
        else if (clock_posedge)
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        grant   = 1'b0;
        start_d = 1'b0;
        irst_d  = 1'b0;
        finish  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant   = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                start_d = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Status bits other than CC/CTE are not an end condition.
                if (is_done(mst_int_status_i)) begin
                    finish  = 1'b1;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                irst_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pulses are re-evaluated every enabled cycle, so each lasts one enable period.
    always_ff @(posedge clock) begin
        if (!rst) begin
            ack_a                <= 1'b0;
            ack_b                <= 1'b0;
            done_a               <= 1'b0;
            done_b               <= 1'b0;
            status_a             <= '0;
            status_b             <= '0;
            owner_o              <= PORT_A;
            mst_start_o          <= 1'b0;
            mst_command_o        <= '0;
            mst_argument_o       <= '0;
            mst_timeout_o        <= '0;
            mst_int_status_rst_o <= 1'b0;
        end else if (clock_posedge) begin
            ack_a                <= grant && (pick_winner == PORT_A);
            ack_b                <= grant && (pick_winner == PORT_B);
            done_a               <= finish && (owner_o == PORT_A);
            done_b               <= finish && (owner_o == PORT_B);
            mst_start_o          <= start_d;
            mst_int_status_rst_o <= irst_d;
            if (grant) begin
                owner_o        <= pick_winner;
                mst_command_o  <= (pick_winner == PORT_B) ? cmd_b : cmd_a;
                mst_argument_o <= (pick_winner == PORT_B) ? arg_b : arg_a;
                mst_timeout_o  <= (pick_winner == PORT_B) ? tmo_b : tmo_a;
            end
            if (finish && owner_o == PORT_A)
                status_a <= mst_int_status_i;
            if (finish && owner_o == PORT_B)
                status_b <= mst_int_status_i;
        end
    end

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// Self-checking bench for sd_cmd_arbiter: directed scenarios plus random traffic
// against a transaction-level model; honours SD_CMD_ARB_RR_EN like the design.
module tb_sd_cmd_arbiter;
    import sd_cmd_arb_pkg::*;

`ifdef SD_CMD_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic                     clock = 1'b0;
    logic                     rst, clock_posedge, req_a, req_b;
    logic [CMD_REG_SIZE-1:0]  cmd_a, cmd_b;
    logic [31:0]              arg_a, arg_b;
    logic [CMD_TIMEOUT_W-1:0] tmo_a, tmo_b;
    logic                     ack_a, ack_b, done_a, done_b;
    logic [INT_CMD_SIZE-1:0]  status_a, status_b;
    logic                     owner_o, mst_start_o, mst_int_status_rst_o;
    logic [CMD_REG_SIZE-1:0]  mst_command_o;
    logic [31:0]              mst_argument_o;
    logic [CMD_TIMEOUT_W-1:0] mst_timeout_o;
    logic [INT_CMD_SIZE-1:0]  mst_int_status_i;

    sd_cmd_arbiter dut (
        .clock(clock), .rst(rst), .clock_posedge(clock_posedge),
        .req_a(req_a), .req_b(req_b), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .arg_a(arg_a), .arg_b(arg_b), .tmo_a(tmo_a), .tmo_b(tmo_b),
        .ack_a(ack_a), .ack_b(ack_b), .done_a(done_a), .done_b(done_b),
        .status_a(status_a), .status_b(status_b), .owner_o(owner_o),
        .mst_start_o(mst_start_o), .mst_command_o(mst_command_o),
        .mst_argument_o(mst_argument_o), .mst_timeout_o(mst_timeout_o),
        .mst_int_status_rst_o(mst_int_status_rst_o),
        .mst_int_status_i(mst_int_status_i)
    );

    initial forever #5 clock = ~clock;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a grant opens a transaction, start follows one
    // enabled cycle later, CC/CTE closes it, and one release cycle frees the bus.
    bit [1:0]                 e_ack, e_done;
    bit                       e_start, e_irst, e_owner;
    logic [CMD_REG_SIZE-1:0]  e_cmd;
    logic [31:0]              e_arg;
    logic [CMD_TIMEOUT_W-1:0] e_tmo;
    logic [INT_CMD_SIZE-1:0]  e_stat [2];
    int                       ecnt, grant_at;
    bit                       busy, closed, last;
    bit                       cmp_on = 1'b0;

    task automatic model_edge();
        bit w;
        if (!rst) begin
            e_ack = 0; e_done = 0; e_start = 0; e_irst = 0; e_owner = 0;
            e_cmd = '0; e_arg = '0; e_tmo = '0; e_stat[0] = '0; e_stat[1] = '0;
            busy = 0; closed = 0; last = 1; ecnt = 0; grant_at = 0;
        end else if (clock_posedge) begin
            ecnt++;
            e_ack = 0; e_done = 0; e_start = 0; e_irst = 0;
            if (!busy) begin
                if (req_a || req_b) begin
                    if (req_a && req_b) w = RR ? !last : 1'b1;
                    else                w = req_b;
                    busy = 1; closed = 0; grant_at = ecnt; last = w;
                    e_ack[w] = 1; e_owner = w;
                    e_cmd = w ? cmd_b : cmd_a;
                    e_arg = w ? arg_b : arg_a;
                    e_tmo = w ? tmo_b : tmo_a;
                end
            end else if (!closed) begin
                if (ecnt == grant_at + 1) e_start = 1;
                else if ((mst_int_status_i & 5'b00101) != 0) begin
                    e_done[e_owner] = 1; e_stat[e_owner] = mst_int_status_i; closed = 1;
                end
            end else begin
                e_irst = 1; busy = 0;
            end
        end
    endtask

    always @(negedge clock) if (cmp_on) begin
        chk("ack_a", 64'(ack_a), 64'(e_ack[0]));
        chk("ack_b", 64'(ack_b), 64'(e_ack[1]));
        chk("done_a", 64'(done_a), 64'(e_done[0]));
        chk("done_b", 64'(done_b), 64'(e_done[1]));
        chk("status_a", 64'(status_a), 64'(e_stat[0]));
        chk("status_b", 64'(status_b), 64'(e_stat[1]));
        chk("owner", 64'(owner_o), 64'(e_owner));
        chk("start", 64'(mst_start_o), 64'(e_start));
        chk("irst", 64'(mst_int_status_rst_o), 64'(e_irst));
        chk("cmd", 64'(mst_command_o), 64'(e_cmd));
        chk("arg", 64'(mst_argument_o), 64'(e_arg));
        chk("tmo", 64'(mst_timeout_o), 64'(e_tmo));
    end

    // Command-master stand-in: answers each start with CC, or CTE|EI on timeout.
    bit                      stub_on, force_nr, pend;
    int                      cnt;
    logic [INT_CMD_SIZE-1:0] st_cur, st_val;

    task automatic stub_update();
        if (!rst || e_irst) begin pend = 0; st_cur = '0; end
        if (e_start) begin
            pend = 1; st_cur = '0;
            if (e_tmo != 0 && (force_nr || $urandom % 3 == 0)) begin
                cnt = int'(e_tmo); st_val = 5'h06;
            end else begin
                cnt = $urandom_range(0, 5); st_val = 5'h01;
            end
        end else if (pend && st_cur == 0) begin
            if (cnt == 0) st_cur = st_val; else cnt--;
        end
        mst_int_status_i = (pend && st_cur == 0 && $urandom % 6 == 0) ? 5'h1A : st_cur;
    endtask

    task automatic tick();
        cmp_on = 1'b1;
        model_edge();
        @(negedge clock);
        #1;
    endtask

    task automatic step(input bit en);
        clock_posedge = en;
        if (stub_on) stub_update();
        tick();
    endtask

    task automatic set_req(input bit p, input logic [CMD_REG_SIZE-1:0] c,
                           input logic [31:0] a, input logic [CMD_TIMEOUT_W-1:0] t);
        if (p) begin req_b = 1; cmd_b = c; arg_b = a; tmo_b = t; end
        else   begin req_a = 1; cmd_a = c; arg_a = a; tmo_a = t; end
    endtask

    task automatic apply_reset(input bit stub);
        rst = 0; req_a = 0; req_b = 0; clock_posedge = 0; mst_int_status_i = '0;
        force_nr = 0; pend = 0; st_cur = '0; stub_on = stub;
        tick(); tick();
        rst = 1;
    endtask

    function automatic logic [CMD_TIMEOUT_W-1:0] rand_tmo();
        return ($urandom % 2) ? '0 : CMD_TIMEOUT_W'($urandom_range(3, 10));
    endfunction

    task automatic drive_random();
        rst = ($urandom % 600) != 0;
        if (e_ack[0]) req_a = 0;
        else if (!req_a) begin
            cmd_a = CMD_REG_SIZE'($urandom); arg_a = $urandom; tmo_a = rand_tmo();
            req_a = ($urandom % 5) == 0;
        end
        if (e_ack[1]) req_b = 0;
        else if (!req_b) begin
            cmd_b = CMD_REG_SIZE'($urandom); arg_b = $urandom; tmo_b = rand_tmo();
            req_b = ($urandom % 5) == 0;
        end
        clock_posedge = ($urandom % 4) != 0;
        if (stub_on) stub_update();
    endtask

    initial begin
        int dcyc, acyc;
        logic sec;
        cmd_a = '0; cmd_b = '0; arg_a = '0; arg_b = '0; tmo_a = '0; tmo_b = '0;

        // Single host command, index 17, completed with CC.
        apply_reset(0);
        chk("rst_owner", 64'(owner_o), 64'd0);
        chk("rst_cmd", 64'(mst_command_o), 64'd0);
        set_req(0, 14'h1119, 32'h200, '0); step(1);
        chk("t1_ack_a", 64'(ack_a), 64'd1);
        chk("t1_owner", 64'(owner_o), 64'd0);
        chk("t1_cmd", 64'(mst_command_o), 64'h1119);
        chk("t1_arg", 64'(mst_argument_o), 64'h200);
        req_a = 0; step(1);
        chk("t1_start", 64'(mst_start_o), 64'd1);
        chk("t1_ack_low", 64'(ack_a), 64'd0);
        step(1);
        chk("t1_start_low", 64'(mst_start_o), 64'd0);
        mst_int_status_i = 5'h01; step(1);
        chk("t1_done_a", 64'(done_a), 64'd1);
        chk("t1_status_a", 64'(status_a), 64'h01);
        step(1);
        chk("t1_irst", 64'(mst_int_status_rst_o), 64'd1);
        chk("t1_done_low", 64'(done_a), 64'd0);
        mst_int_status_i = '0; step(1);
        chk("t1_irst_low", 64'(mst_int_status_rst_o), 64'd0);

        // Simultaneous requests straight after reset.
        apply_reset(1);
        set_req(0, 14'h0A01, 32'h1, '0); set_req(1, 14'h0B02, 32'h2, '0); step(1);
        chk("t2_first_owner", 64'(owner_o), RR ? 64'd0 : 64'd1);
        if (e_ack[0]) req_a = 0;
        if (e_ack[1]) req_b = 0;
        dcyc = -1; acyc = -1; sec = 1'bx;
        for (int i = 0; i < 60 && acyc < 0; i++) begin
            step(1);
            if (e_ack[0]) req_a = 0;
            if (e_ack[1]) req_b = 0;
            if (e_done != 0 && dcyc < 0) dcyc = i;
            if (dcyc >= 0 && e_ack != 0) begin acyc = i; sec = owner_o; end
        end
        chk("t2_second_owner", 64'(sec), RR ? 64'd1 : 64'd0);
        chk("t2_gap", 64'(acyc - dcyc), 64'd2);

        // Port B with timeout 8 and no card response.
        apply_reset(1);
        force_nr = 1;
        set_req(1, 14'h0C1A, 32'h0, 24'd8); step(1);
        req_b = 0;
        for (int i = 0; i < 60 && e_done[1] == 0; i++) step(1);
        chk("t3_done_b", 64'(done_b), 64'd1);
        chk("t3_status_b", 64'(status_b), 64'h06);
        chk("t3_owner", 64'(owner_o), 64'd1);
        force_nr = 0;

        // B arrives while A is waiting on the master.
        apply_reset(1);
        set_req(0, 14'h2A15, 32'hDEAD0001, '0); step(1);
        req_a = 0; step(1);
        set_req(1, 14'h0D00, 32'h1, '0);
        dcyc = -1; acyc = -1;
        for (int i = 0; i < 60 && acyc < 0; i++) begin
            step(1);
            if (dcyc < 0) chk("t4_cmd_hold", 64'(mst_command_o), 64'h2A15);
            if (e_done[0] && dcyc < 0) dcyc = i;
            if (e_ack[1]) begin acyc = i; req_b = 0; end
        end
        chk("t4_gap", 64'(acyc - dcyc), 64'd2);

        // Enable held low in WAIT while CC is already present.
        apply_reset(0);
        set_req(0, 14'h1119, 32'h5, '0); step(1);
        req_a = 0; step(1); step(1);
        mst_int_status_i = 5'h01;
        for (int i = 0; i < 3; i++) begin
            step(0);
            chk("t5_no_done", 64'(done_a), 64'd0);
        end
        step(1);
        chk("t5_done", 64'(done_a), 64'd1);
        step(1); mst_int_status_i = '0; step(1);

        // Reset in WAIT aborts without done; a fresh request is then served.
        apply_reset(0);
        set_req(0, 14'h1119, 32'h7, '0); step(1);
        req_a = 0; step(1); step(1);
        mst_int_status_i = 5'h01; rst = 0; step(0);
        chk("t6_done", 64'(done_a), 64'd0);
        chk("t6_cmd", 64'(mst_command_o), 64'd0);
        chk("t6_arg", 64'(mst_argument_o), 64'd0);
        rst = 1; mst_int_status_i = '0; step(1);
        set_req(0, 14'h0511, 32'h9, '0); step(1);
        chk("t6_ack", 64'(ack_a), 64'd1);
        req_a = 0; step(1); step(1);
        mst_int_status_i = 5'h01; step(1);
        chk("t6_done2", 64'(done_a), 64'd1);
        chk("t6_status", 64'(status_a), 64'h01);
        step(1); mst_int_status_i = '0; step(1);

        // Random traffic, random enables, occasional reset.
        apply_reset(1);
        for (int i = 0; i < 4000; i++) begin
            drive_random();
            tick();
        end

        cmp_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
